mult_arbiter: RTL and testbench
===============================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, operand width of the shared serial-parallel multiplier.
REQ-002 SHALL have parameter R, default 3, number of requesters (2..8).
REQ-003 SHALL have parameter TIMEOUT, default 4*N, maximum cycles in WAIT before error.
REQ-004 SHALL have clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have req_valid  input  R  per-requester operation request.
REQ-007 SHALL have req_a, req_b  input  R*N each  packed signed operands, slice i belongs to requester i.
REQ-008 SHALL have req_ready  output  R  one-hot accept strobe for the granted requester.
REQ-009 SHALL have rsp_valid  output  R  one-hot result-available flag.
REQ-010 SHALL have rsp_result  output  2N  signed product for the requester flagged in rsp_valid.
REQ-011 SHALL have rsp_error  output  1  qualifies rsp_valid: the multiplier timed out and rsp_result is 0.
REQ-012 SHALL have rsp_ready  input  R  per-requester result acceptance.
REQ-013 SHALL have mul_start  output  1  start pulse to the multiplier.
REQ-014 SHALL have mul_a, mul_b  output  N each  operands to the multiplier.
REQ-015 SHALL have mul_result  input  2N  and mul_done  input  1  from the multiplier (done is a level, cleared by the multiplier one cycle after start).

Function
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-017 IDLE: if any req_valid, SHALL grant one requester round-robin (search starts at last_grant+1 mod R), latch its operands and index, pulse req_ready[grant] for that cycle, go to ISSUE.
REQ-018 ISSUE: SHALL drive mul_start=1 for exactly one cycle with latched operands on mul_a/mul_b, clear the timeout counter, go to WAIT.
REQ-019 WAIT: SHALL sample mul_done only in this state; on mul_done=1 latch mul_result into rsp_result, rsp_error=0, go to RESP.
REQ-020 WAIT: SHALL increment the timeout counter each cycle; when it reaches TIMEOUT without mul_done, set rsp_result=0, rsp_error=1, go to RESP.
REQ-021 RESP: SHALL hold rsp_valid[grant]=1 and rsp_result/rsp_error stable until rsp_ready[grant]=1, then update last_grant=grant and go to IDLE.
REQ-022 rsp_ready bits of non-granted requesters SHALL be ignored; req_valid changes outside IDLE SHALL be ignored.
REQ-023 One operation SHALL be in flight at most; a new grant SHALL occur no earlier than the cycle after the RESP handshake.
REQ-024 Round-robin SHALL wrap from index R-1 to 0; a lone requester SHALL be granted repeatedly.
REQ-025 mul_a/mul_b SHALL hold latched operands from ISSUE until leaving WAIT.
REQ-026 rsp_result width SHALL be 2N; no truncation, sign preserved as delivered by the multiplier.

Reset
REQ-027 On rst=1 at a clock edge SHALL enter IDLE; req_ready=0, rsp_valid=0, rsp_result=0, rsp_error=0, mul_start=0, mul_a=0, mul_b=0, last_grant=R-1 (so index 0 wins first).
REQ-028 Reset mid-operation SHALL abandon the operation without a response; the requester must re-request.
REQ-029 Reset SHALL take precedence over every other event in the same cycle.

Structure
REQ-030 Shared package mult_ctrl_pkg SHALL hold the state encoding constants and default N, R, TIMEOUT values.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: request vector, last grant; outputs: one-hot grant, index, any).
REQ-032 Timeout counter width SHALL be $clog2(TIMEOUT+1).

Verification (N=4, R=3, real multiplier attached)
REQ-033 Requester 1 alone, a=3, b=-2 -> req_ready[1] one cycle, mul_start one cycle later, rsp_valid[1] with rsp_result=8'hFA, rsp_error=0.
REQ-034 All three requesters valid continuously after reset -> grant order 0,1,2,0; each response matches (a=-8,b=-8 -> 8'h40; a=7,b=-1 -> 8'hF9).
REQ-035 rsp_ready[0] held low 10 cycles -> rsp_valid[0] and rsp_result held stable; no mul_start; other requests wait.
REQ-036 Multiplier stubbed with mul_done tied 0 -> after TIMEOUT=16 cycles in WAIT, rsp_valid set, rsp_error=1, rsp_result=0.
REQ-037 rst asserted in WAIT -> next cycle all outputs at reset values, no rsp_valid; subsequent request from requester 2 completes correctly.
REQ-038 rsp_ready asserted on a non-granted index during RESP -> no handshake, state stays RESP.

Source files
------------

// File: rtl/mult_arbiter_pkg.sv
// Shared constants and state encoding for the arbitrated multiplier controller.
// Holds the default operand width, requester count and timeout.
package mult_ctrl_pkg;

    localparam int DEF_N       = 4;
    localparam int DEF_R       = 3;
    localparam int DEF_TIMEOUT = 4 * DEF_N;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int idx_w(input int r);
        return (r > 1) ? $clog2(r) : 1;
    endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Requester, response and multiplier signals of the arbiter, bundled.
// slave = arbiter side; master = requesters plus the multiplier.
interface mult_arbiter_if
    import mult_ctrl_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int R = DEF_R
);
    logic [R-1:0]     req_valid;
    logic [R*N-1:0]   req_a;
    logic [R*N-1:0]   req_b;
    logic [R-1:0]     req_ready;
    logic [R-1:0]     rsp_valid;
    logic [2*N-1:0]   rsp_result;
    logic             rsp_error;
    logic [R-1:0]     rsp_ready;
    logic             mul_start;
    logic [N-1:0]     mul_a;
    logic [N-1:0]     mul_b;
    logic [2*N-1:0]   mul_result;
    logic             mul_done;

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready, mul_result, mul_done,
        output req_ready, rsp_valid, rsp_result, rsp_error, mul_start, mul_a, mul_b
    );

    modport master (
        output req_valid, req_a, req_b, rsp_ready, mul_result, mul_done,
        input  req_ready, rsp_valid, rsp_result, rsp_error, mul_start, mul_a, mul_b
    );

endinterface

// File: rtl/mult_arbiter_rr_arbiter.sv
// Round-robin pick: the first requester after last_i (wrapping) wins.
// Purely combinational, zero latency; no backpressure of its own.
module rr_arbiter
    import mult_ctrl_pkg::*;
#(
    parameter int R  = DEF_R,
    parameter int IW = idx_w(R)
) (
    input  logic [R-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [R-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    logic [IW-1:0] pos;

    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        pos   = '0;
        // Walk from farthest to nearest so the nearest match overwrites the rest.
        for (int i = R; i >= 1; i--) begin
            pos = IW'((int'(last_i) + i) % R);
            if (req_i[pos]) begin
                idx_o = pos;
                any_o = 1'b1;
            end
        end
        grant_o = any_o ? (R'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one multiplier among R requesters, round-robin, one op in flight.
// Latency: grant, 1 issue cycle, multiplier time (<= TIMEOUT), then response held until rsp_ready.
module mult_arbiter
    import mult_ctrl_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int R       = DEF_R,
    parameter int TIMEOUT = 4 * N
) (
    input  logic          clk,
    input  logic          rst,
    mult_arbiter_if.slave bus
);
    localparam int IW   = idx_w(R);
    localparam int CNTW = $clog2(TIMEOUT + 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [IW-1:0]   last_q, last_d;
    logic [N-1:0]    a_q, a_d;
    logic [N-1:0]    b_q, b_d;
    logic [2*N-1:0]  res_q, res_d;
    logic            err_q, err_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [R-1:0]    arb_grant;
    logic [R-1:0]    req_rdy_c;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;

    rr_arbiter #(.R(R), .IW(IW)) u_rr (
        .req_i   (bus.req_valid),
        .last_i  (last_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .any_o   (arb_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= IW'(R - 1);
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        req_rdy_c = '0;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    grant_d   = arb_idx;
                    req_rdy_c = arb_grant;
                    for (int i = 0; i < R; i++) begin
                        if (arb_idx == IW'(i)) begin
                            a_d = bus.req_a[i*N +: N];
                            b_d = bus.req_b[i*N +: N];
                        end
                    end
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNTW'(1);
                if (bus.mul_done) begin
                    res_d   = bus.mul_result;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_d == CNTW'(TIMEOUT)) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                // Only the granted requester's rsp_ready completes the handshake.
                if (bus.rsp_ready[grant_q]) begin
                    last_d  = grant_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.req_ready  = rst ? '0 : req_rdy_c;
    assign bus.rsp_valid  = (state_q == ST_RESP) ? (R'(1) << grant_q) : '0;
    assign bus.rsp_result = res_q;
    assign bus.rsp_error  = err_q;
    assign bus.mul_start  = (state_q == ST_ISSUE);
    assign bus.mul_a      = a_q;
    assign bus.mul_b      = b_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: behavioural multiplier with random latency plus a
// transaction-level round-robin / product model.
module tb_mult_arbiter;
    import mult_ctrl_pkg::*;

    localparam int N  = 4;
    localparam int R  = 3;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mult_arbiter_if #(.N(N), .R(R)) bus ();

    mult_arbiter #(.N(N), .R(R), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [R-1:0] rv = '0;
    logic [R-1:0] rr = '1;
    logic [N-1:0] opa [R];
    logic [N-1:0] opb [R];

    assign bus.req_valid = rv;
    assign bus.rsp_ready = rr;
    assign bus.req_a     = {opa[2], opa[1], opa[0]};
    assign bus.req_b     = {opb[2], opb[1], opb[0]};

    // Multiplier: done cleared on start, raised after a random 1..6 cycles.
    logic       m_done = 1'b0;
    logic [7:0] m_res  = '0;
    logic       m_busy = 1'b0;
    int         m_cnt  = 0;
    logic [3:0] m_a    = '0;
    logic [3:0] m_b    = '0;
    bit         stub   = 1'b0;

    assign bus.mul_done   = m_done;
    assign bus.mul_result = m_res;

    always @(posedge clk) begin
        if (bus.mul_start) begin
            m_done <= 1'b0;
            m_busy <= 1'b1;
            m_cnt  <= $urandom_range(1, 6);
            m_a    <= bus.mul_a;
            m_b    <= bus.mul_b;
        end else if (stub) begin
            m_done <= 1'b0;
        end else if (m_busy) begin
            if (m_cnt <= 1) begin
                m_done <= 1'b1;
                m_res  <= 8'($signed({{4{m_a[3]}}, m_a}) * $signed({{4{m_b[3]}}, m_b}));
                m_busy <= 1'b0;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    typedef struct {
        int         g;
        logic [2:0] rdy, rdy2, vld;
        logic       st, st2, err;
        logic [3:0] ma, mb, ea, eb;
        logic [7:0] res;
        int         lat;
        bit         ok;
    } obs_t;

    int n_run  = 0;
    int n_fail = 0;
    int last_g = R - 1;

    function automatic logic [7:0] prod(input logic [3:0] a, input logic [3:0] b);
        int p;
        p = $signed(a) * $signed(b);
        return p[7:0];
    endfunction

    function automatic int predict(input logic [2:0] v, input int last);
        for (int i = 1; i <= R; i++) begin
            if (v[(last + i) % R]) return (last + i) % R;
        end
        return -1;
    endfunction

    // Runs one transaction and records what the DUT showed; starts/ends just after a rising edge.
    task automatic observe_op(input bit drop, output obs_t o);
        bit found;
        o = '{default: 0};
        o.g = -1;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.req_ready !== '0) begin
                found = 1'b1;
                o.rdy = bus.req_ready;
                for (int j = 0; j < R; j++) if (bus.req_ready[j] === 1'b1) o.g = j;
            end
            @(posedge clk); #1;
            if (found) break;
        end
        if (!found || o.g < 0) begin
            o.ok = 1'b0;
            return;
        end
        o.ea = opa[o.g];
        o.eb = opb[o.g];
        if (drop) rv[o.g] = 1'b0;
        else begin
            opa[o.g] = 4'($urandom);
            opb[o.g] = 4'($urandom);
        end
        @(negedge clk);
        o.st   = bus.mul_start;
        o.ma   = bus.mul_a;
        o.mb   = bus.mul_b;
        o.rdy2 = bus.req_ready;
        found  = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (k == 1) o.st2 = bus.mul_start;
            if (bus.rsp_valid !== '0) begin
                found = 1'b1;
                o.lat = k;
                o.vld = bus.rsp_valid;
                o.res = bus.rsp_result;
                o.err = bus.rsp_error;
                break;
            end
        end
        @(posedge clk); #1;
        o.ok = found;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        rv  = '0;
        rr  = '1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        last_g = R - 1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rv  = '1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        n_run++; if (bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_req_ready: got %b want 000", bus.req_ready); end
        n_run++; if (bus.rsp_valid !== 3'b000) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 000", bus.rsp_valid); end
        n_run++; if (bus.rsp_result !== 8'h00) begin n_fail++; $display("FAIL reset_rsp_result: got %h want 00", bus.rsp_result); end
        n_run++; if (bus.rsp_error !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_error: got %b want 0", bus.rsp_error); end
        n_run++; if (bus.mul_start !== 1'b0) begin n_fail++; $display("FAIL reset_mul_start: got %b want 0", bus.mul_start); end
        n_run++; if ({bus.mul_a, bus.mul_b} !== 8'h00) begin n_fail++; $display("FAIL reset_mul_ops: got %h want 00", {bus.mul_a, bus.mul_b}); end
        @(posedge clk); #1;
        rst = 1'b0;
        rv  = '0;
        last_g = R - 1;
    endtask

    task automatic test_single;
        obs_t o;
        rv = 3'b010;
        opa[1] = 4'd3;
        opb[1] = 4'hE;
        observe_op(1'b1, o);
        n_run++; if (!o.ok) begin n_fail++; $display("FAIL single_done: got no transaction, want one"); end
        n_run++; if (o.rdy !== 3'b010) begin n_fail++; $display("FAIL single_req_ready: got %b want 010", o.rdy); end
        n_run++; if (o.rdy2 !== 3'b000) begin n_fail++; $display("FAIL single_req_ready_pulse: got %b want 000", o.rdy2); end
        n_run++; if ({o.st, o.st2} !== 2'b10) begin n_fail++; $display("FAIL single_mul_start: got %b want 10", {o.st, o.st2}); end
        n_run++; if ({o.ma, o.mb} !== 8'h3E) begin n_fail++; $display("FAIL single_mul_ops: got %h want 3e", {o.ma, o.mb}); end
        n_run++; if (o.vld !== 3'b010) begin n_fail++; $display("FAIL single_rsp_valid: got %b want 010", o.vld); end
        n_run++; if (o.res !== 8'hFA) begin n_fail++; $display("FAIL single_result: got %h want fa", o.res); end
        n_run++; if (o.err !== 1'b0) begin n_fail++; $display("FAIL single_error: got %b want 0", o.err); end
        last_g = 1;
    endtask

    task automatic test_round_robin;
        obs_t o;
        int want [4] = '{0, 1, 2, 0};
        logic [7:0] first_res [2] = '{8'h40, 8'hF9};
        do_reset();
        opa[0] = 4'h8; opb[0] = 4'h8;
        opa[1] = 4'h7; opb[1] = 4'hF;
        opa[2] = 4'($urandom); opb[2] = 4'($urandom);
        rv = 3'b111;
        for (int i = 0; i < 4; i++) begin
            observe_op(1'b0, o);
            n_run++; if (o.g !== want[i]) begin n_fail++; $display("FAIL rr_grant%0d: got %0d want %0d", i, o.g, want[i]); end
            n_run++; if (o.res !== prod(o.ea, o.eb) || o.err !== 1'b0) begin n_fail++; $display("FAIL rr_result%0d: got %h/%b want %h/0", i, o.res, o.err, prod(o.ea, o.eb)); end
            if (i < 2) begin
                n_run++; if (o.res !== first_res[i]) begin n_fail++; $display("FAIL rr_known%0d: got %h want %h", i, o.res, first_res[i]); end
            end
            last_g = want[i];
        end
        rv = '0;
    endtask

    task automatic test_lone;
        obs_t o;
        for (int i = 0; i < 3; i++) begin
            rv = 3'b100;
            opa[2] = 4'($urandom); opb[2] = 4'($urandom);
            observe_op(1'b1, o);
            n_run++; if (o.g !== 2 || o.res !== prod(o.ea, o.eb)) begin n_fail++; $display("FAIL lone%0d: got grant %0d res %h want grant 2 res %h", i, o.g, o.res, prod(o.ea, o.eb)); end
        end
        last_g = 2;
    endtask

    task automatic test_stall;
        obs_t o;
        do_reset();
        for (int i = 0; i < R; i++) begin opa[i] = 4'($urandom); opb[i] = 4'($urandom); end
        rv = 3'b111;
        rr = 3'b110;
        observe_op(1'b1, o);
        n_run++; if (o.g !== 0 || o.vld !== 3'b001 || o.res !== prod(o.ea, o.eb)) begin n_fail++; $display("FAIL stall_first: got g%0d vld %b res %h want g0 vld 001 res %h", o.g, o.vld, o.res, prod(o.ea, o.eb)); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_run++;
            if (bus.rsp_valid !== 3'b001 || bus.rsp_result !== o.res || bus.rsp_error !== 1'b0 ||
                bus.mul_start !== 1'b0 || bus.req_ready !== 3'b000) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got vld %b res %h start %b rdy %b want vld 001 res %h start 0 rdy 000",
                         c, bus.rsp_valid, bus.rsp_result, bus.mul_start, bus.req_ready, o.res);
            end
            @(posedge clk); #1;
        end
        rr = '1;
        last_g = 0;
        for (int i = 1; i <= 2; i++) begin
            observe_op(1'b1, o);
            n_run++; if (o.g !== i || o.res !== prod(o.ea, o.eb)) begin n_fail++; $display("FAIL stall_next%0d: got grant %0d res %h want grant %0d res %h", i, o.g, o.res, i, prod(o.ea, o.eb)); end
            last_g = i;
        end
        rv = '0;
    endtask

    task automatic test_random;
        obs_t o;
        int exp_g;
        for (int t = 0; t < 16; t++) begin
            rv = rv | 3'($urandom_range(0, 7));
            if (rv == 3'b000) rv = 3'($urandom_range(1, 7));
            for (int i = 0; i < R; i++) begin opa[i] = 4'($urandom); opb[i] = 4'($urandom); end
            exp_g = predict(rv, last_g);
            observe_op(1'b1, o);
            n_run++; if (o.g !== exp_g || o.vld !== (3'b001 << exp_g)) begin n_fail++; $display("FAIL rand%0d_grant: got %0d vld %b want %0d", t, o.g, o.vld, exp_g); end
            n_run++; if ({o.ma, o.mb} !== {o.ea, o.eb} || o.res !== prod(o.ea, o.eb) || o.err !== 1'b0) begin
                n_fail++;
                $display("FAIL rand%0d_data: got ops %h res %h err %b want ops %h res %h err 0", t, {o.ma, o.mb}, o.res, o.err, {o.ea, o.eb}, prod(o.ea, o.eb));
            end
            last_g = exp_g;
        end
        rv = '0;
    endtask

    task automatic test_timeout;
        obs_t o;
        int exp_g;
        stub = 1'b1;
        rv = 3'b001;
        opa[0] = 4'd5; opb[0] = 4'd5;
        exp_g = predict(rv, last_g);
        observe_op(1'b1, o);
        n_run++; if (!o.ok || o.vld !== (3'b001 << exp_g)) begin n_fail++; $display("FAIL timeout_valid: got %b want %b", o.vld, 3'b001 << exp_g); end
        n_run++; if (o.err !== 1'b1 || o.res !== 8'h00) begin n_fail++; $display("FAIL timeout_error: got err %b res %h want err 1 res 00", o.err, o.res); end
        n_run++; if (o.lat !== TO + 1) begin n_fail++; $display("FAIL timeout_latency: got %0d want %0d", o.lat, TO + 1); end
        last_g = exp_g;
        stub = 1'b0;
    endtask

    task automatic test_reset_mid;
        obs_t o;
        bit found;
        int hits;
        found = 1'b0;
        hits = 0;
        stub = 1'b1;
        rv = 3'b001;
        opa[0] = 4'd5; opb[0] = 4'd3;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.req_ready[0] === 1'b1) found = 1'b1;
            @(posedge clk); #1;
            if (found) break;
        end
        n_run++; if (!found) begin n_fail++; $display("FAIL rstmid_grant: got no grant want grant 0"); end
        rv = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_run++;
        if ({bus.rsp_valid, bus.req_ready, bus.mul_start, bus.mul_a, bus.mul_b, bus.rsp_result, bus.rsp_error} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got vld %b rdy %b start %b a %h b %h res %h err %b want all zero",
                     bus.rsp_valid, bus.req_ready, bus.mul_start, bus.mul_a, bus.mul_b, bus.rsp_result, bus.rsp_error);
        end
        stub = 1'b0;
        last_g = R - 1;
        @(posedge clk); #1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 3'b000) hits++;
            @(posedge clk); #1;
        end
        n_run++; if (hits !== 0) begin n_fail++; $display("FAIL rstmid_no_rsp: got %0d cycles with rsp_valid want 0", hits); end
        rv = 3'b100;
        opa[2] = 4'($urandom); opb[2] = 4'($urandom);
        observe_op(1'b1, o);
        n_run++; if (o.g !== 2 || o.vld !== 3'b100) begin n_fail++; $display("FAIL rstmid_regrant: got grant %0d vld %b want 2 / 100", o.g, o.vld); end
        n_run++; if (o.res !== prod(o.ea, o.eb) || o.err !== 1'b0) begin n_fail++; $display("FAIL rstmid_result: got %h/%b want %h/0", o.res, o.err, prod(o.ea, o.eb)); end
        last_g = 2;
    endtask

    initial begin
        for (int i = 0; i < R; i++) begin opa[i] = '0; opb[i] = '0; end
        test_reset();
        test_single();
        test_round_robin();
        test_lone();
        test_stall();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

endmodule
